// File: rtl/fp32_mul_pkg.sv
// Shared types for the FP32 multiplier issue/collect stage.
// Flag ordering matches the multiplier core: {nan, inf, ovf, unf}.
package fp32_mul_pkg;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic nan;
        logic inf;
        logic ovf;
        logic unf;
    } fp_flags_t;

    localparam fp_flags_t FLAGS_TIMEOUT = '{nan: 1'b1, inf: 1'b0, ovf: 1'b0, unf: 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } seq_state_t;

endpackage

// File: rtl/fp32_sync_fifo.sv
// Single-clock FIFO; pop_dat shows the head combinationally (zero-latency read).
// Pushes while full and pops while empty are ignored, so callers may drive them freely.
module fp32_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/fp32_mul_sequencer.sv
// Issue/collect stage for the FP32 multiplier: buffers operand pairs, runs one multiply
// at a time, returns product/flags on a valid/ready stream, and times out a hung core.
module fp32_mul_sequencer
    import fp32_mul_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [31:0]      op_a_i,
    input  logic [31:0]      op_b_i,
    output logic [31:0]      mul_a_o,
    output logic [31:0]      mul_b_o,
    output logic             mul_start_o,
    input  logic             mul_done_i,
    input  logic [31:0]      mul_product_i,
    input  logic [3:0]       mul_flags_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_product_o,
    output logic [3:0]       res_flags_o,
    output logic             res_timeout_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [63:0]      fifo_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             done_q;
    logic             done_edge;
    logic [TW-1:0]    timer;
    logic             load_ops;
    logic             timer_clr;
    logic             timer_inc;
    logic             cap_done;
    logic             cap_timeout;
    logic             res_fire;
    logic [31:0]      mul_a_q;
    logic [31:0]      mul_b_q;
    logic [31:0]      res_product_q;
    fp_flags_t        res_flags_q;
    logic             res_timeout_q;
    logic [CNT_W-1:0] count_q;

    fp32_sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (op_valid_i && !fifo_full),
        .push_dat ({op_a_i, op_b_i}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A done level left high from an earlier op must not count as a new completion.
    assign done_edge = mul_done_i && !done_q;

    always_comb begin
        state_nxt   = state;
        fifo_pop    = 1'b0;
        load_ops    = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        res_fire    = 1'b0;
        mul_start_o = 1'b0;
        res_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load_ops  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_o = 1'b1;
                timer_clr   = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (done_edge) begin
                    cap_done  = 1'b1;
                    state_nxt = OUT;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    cap_timeout = 1'b1;
                    state_nxt   = OUT;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            OUT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    res_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            done_q        <= 1'b0;
            timer         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            res_product_q <= '0;
            res_flags_q   <= '0;
            res_timeout_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= mul_done_i;
            if (load_ops) begin
                mul_a_q <= fifo_dat[63:32];
                mul_b_q <= fifo_dat[31:0];
            end
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + TW'(1);
            if (cap_done) begin
                res_product_q <= mul_product_i;
                res_flags_q   <= fp_flags_t'(mul_flags_i);
                res_timeout_q <= 1'b0;
            end else if (cap_timeout) begin
                res_product_q <= FP32_QNAN;
                res_flags_q   <= FLAGS_TIMEOUT;
                res_timeout_q <= 1'b1;
            end
            if (res_fire) count_q <= count_q + CNT_W'(1);
        end
    end

    assign op_ready_o    = !fifo_full;
    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;
    assign res_product_o = res_product_q;
    assign res_flags_o   = res_flags_q;
    assign res_timeout_o = res_timeout_q;
    assign count_o       = count_q;
    assign busy_o        = (state != IDLE) || !fifo_empty;

endmodule
